// File: rtl/mux21_pkg.sv
// Shared encodings for the two-requester round-robin mux arbiter.
package mux21_pkg;

  localparam int unsigned GNT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_e;

  localparam logic [GNT_W-1:0] GNT_NONE = 2'b00;
  localparam logic [GNT_W-1:0] GNT_0    = 2'b01;
  localparam logic [GNT_W-1:0] GNT_1    = 2'b10;

endpackage : mux21_pkg

// File: rtl/mux21_bus.sv
// Gated 2:1 datapath mux: passes the selected input when enabled, zero otherwise.
module mux21_bus #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             en_i,
  input  logic             sel_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic [WIDTH-1:0] y_c_o
);

  // Select and gate the shared data path
  always_comb begin
    y_c_o = '0;
    if (en_i) begin
      y_c_o = sel_i ? data1_i : data0_i;
    end
  end

endmodule : mux21_bus

// File: rtl/mux21_arbiter.sv
// Round-robin arbiter sharing one gated 2:1 mux between two requesters.
// Optional build macro MUX21_ARB_PREEMPT_EN: forces a handover after MAX_HOLD
// consecutive grant cycles while the other side is waiting.
module mux21_arbiter
  import mux21_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       grant,
  output logic             sel,
  output logic             en,
  output logic [WIDTH-1:0] y
);

  localparam int unsigned HOLD_W = 8;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux21_arbiter: MAX_HOLD must be in 2..255");
  end

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic [GNT_W-1:0] grant_q;
  logic             sel_q;
  logic             en_q;
  logic             hold_sat_c;

`ifdef MUX21_ARB_PREEMPT_EN
  logic [HOLD_W-1:0] hold_q, hold_d;

  // Current grant has used up its hold budget
  always_comb begin
    hold_sat_c = (hold_q == HOLD_W'(MAX_HOLD - 1));
  end
`else
  // Without preemption a held request keeps the grant indefinitely
  always_comb begin
    hold_sat_c = 1'b0;
  end
`endif

  // Next grant: handover without bubble, tie broken away from the last grantee
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_d = last_q ? ST_GNT0 : ST_GNT1;
        end else if (req0) begin
          state_d = ST_GNT0;
        end else if (req1) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT0: begin
        if (!req0) begin
          state_d = req1 ? ST_GNT1 : ST_IDLE;
        end else if (req1 && hold_sat_c) begin
          state_d = ST_GNT1;
        end
      end
      ST_GNT1: begin
        if (!req1) begin
          state_d = req0 ? ST_GNT0 : ST_IDLE;
        end else if (req0 && hold_sat_c) begin
          state_d = ST_GNT0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_GNT0) begin
      last_d = 1'b0;
    end else if (state_d == ST_GNT1) begin
      last_d = 1'b1;
    end
  end

`ifdef MUX21_ARB_PREEMPT_EN
  // Consecutive-cycle counter for the current grant, saturating at MAX_HOLD-1
  always_comb begin
    hold_d = '0;
    if (state_d != ST_IDLE && state_d == state_q) begin
      hold_d = hold_sat_c ? hold_q : hold_q + HOLD_W'(1);
    end
  end
`endif

  // State, round-robin pointer and registered mux controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      grant_q <= GNT_NONE;
      sel_q   <= 1'b0;
      en_q    <= 1'b0;
`ifdef MUX21_ARB_PREEMPT_EN
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef MUX21_ARB_PREEMPT_EN
      hold_q  <= hold_d;
`endif
      unique case (state_d)
        ST_GNT0: begin
          grant_q <= GNT_0;
          sel_q   <= 1'b0;
          en_q    <= 1'b1;
        end
        ST_GNT1: begin
          grant_q <= GNT_1;
          sel_q   <= 1'b1;
          en_q    <= 1'b1;
        end
        default: begin
          grant_q <= GNT_NONE;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign grant = grant_q;
  assign sel   = sel_q;
  assign en    = en_q;

  mux21_bus #(
    .WIDTH(WIDTH)
  ) u_bus (
    .en_i    (en_q),
    .sel_i   (sel_q),
    .data0_i (data0),
    .data1_i (data1),
    .y_c_o   (y)
  );

endmodule : mux21_arbiter

// File: doc/mux21_arbiter.md
Name: mux21_arbiter

Overview:
Round-robin arbiter and sequencer that shares one gated 2-to-1 mux datapath between two requesters.
- Grants exactly one requester at a time.
- Drives the mux select and enable from registered state.
- Presents the granted requester's data on a single WIDTH-bit output.
- Sits between two producer blocks and a shared downstream consumer.

Parameters:
WIDTH, 8, data width of each requester input and of the output.
MAX_HOLD, 4, max consecutive grant cycles while the other side waits (used only with MUX21_ARB_PREEMPT_EN); legal range 2..255.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
req0  input  1  requester 0 wants the mux; held high for the whole transfer.
req1  input  1  requester 1 wants the mux; held high for the whole transfer.
data0  input  WIDTH  requester 0 data.
data1  input  WIDTH  requester 1 data.
grant  output  2  one-hot grant: 01 = req0, 10 = req1, 00 = none; registered.
sel  output  1  mux select: 0 = data0, 1 = data1; registered.
en  output  1  mux enable, high in any grant state; registered.
y  output  WIDTH  en ? (sel ? data1 : data0) : 0; combinational from the registered sel/en.

Behaviour:
- Reset:
  - States: IDLE, GNT0, GNT1. Reset to IDLE.
  - Reset values: grant=00, sel=0, en=0, y=0, last=1 (last = most recent grantee), hold_cnt=0.
  - Reset takes effect immediately, with no clock edge required.
- State outputs:
  - IDLE: grant=00, en=0, sel holds its last value.
  - GNT0: grant=01, en=1, sel=0.
  - GNT1: grant=10, en=1, sel=1.
- Latency: request sampled at edge N gives grant visible after edge N (one-cycle latency). y follows data combinationally while granted.
- IDLE transitions:
  - Only req0 → GNT0.
  - Only req1 → GNT1.
  - Both → grant the side != last.
  - Neither → stay in IDLE.
- GNTk transitions:
  - req_k low and other req high → go directly to the other grant, no IDLE bubble.
  - req_k low and other req low → IDLE.
  - req_k high → stay, except for preemption (see Optional Feature).
- last updates on every entry to GNT0/GNT1.
- hold_cnt:
  - Clears on every grant change and in IDLE.
  - Increments each cycle the same grant is kept.
  - Saturates at MAX_HOLD-1.
- grant is never 11. en=0 implies grant=00 and y=0.
- Async reset asserted mid-grant: outputs go to reset values immediately. After release, arbitration restarts with last=1, so req0 wins a tie.

Optional Feature:
Macro MUX21_ARB_PREEMPT_EN.
- Defined: in GNTk with req_k high, the other req high and hold_cnt==MAX_HOLD-1, the next edge switches to the other grant. hold_cnt clears and last updates.
- Undefined: no preemption; a held request keeps the grant indefinitely. The hold_cnt logic is compiled out.

Decomposition:
Shared package mux21_pkg holds:
- State encodings: ST_IDLE=2'd0, ST_GNT0=2'd1, ST_GNT1=2'd2.
- Grant constants: GNT_NONE=2'b00, GNT_0=2'b01, GNT_1=2'b10.

One natural sub-module: mux21_bus, a WIDTH-parameterised gated 2:1 mux (en, sel, data0, data1 → y), instantiated once. The FSM, last and hold_cnt stay in mux21_arbiter.

Test Plan:
- Reset: rst_n=0 with req0=req1=1 → grant=00, en=0, sel=0, y=8'h00 with no clock edge; held until release.
- Single requester: req0=1, data0=8'hA5 → after the next edge grant=01, y=8'hA5. Drop req0 → after the next edge grant=00, y=8'h00.
- Tie and handover: both reqs rise together after reset → grant=01 first. Drop req0 with req1 held, data1=8'h3C → next edge grant=10, y=8'h3C, no cycle with grant=00.
- Preemption, MAX_HOLD=4, both reqs held continuously:
  - MUX21_ARB_PREEMPT_EN defined → grant 01 for 4 cycles, 10 for 4 cycles, repeating.
  - Undefined → grant=01 for the whole test.
- Reset mid-grant: in GNT1, pull rst_n low between edges → grant=00, en=0 immediately. Release with both reqs high → grant=01 next edge.
- Fairness: req1 alone is granted; release it, then raise both → grant=01, since last=1.
